// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, port indices
// and the command-bus values driven while no access is in progress.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCmd    = 2'd1,
        StRdWait = 2'd2,
        StResp   = 2'd3
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam logic IDLE_CE  = 1'b0;
    localparam logic IDLE_CSB = 1'b1;
    localparam logic IDLE_WEB = 1'b1;
    localparam logic IDLE_OEB = 1'b1;

    localparam int unsigned GNT_CNT_W = 16;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port that
// was not granted last. Priority starts at port A out of reset.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       gnt_idx_o,
    output logic       gnt_valid_o
);

    logic prio_q, prio_d;
    logic gnt_idx;
    logic gnt_valid;

    always_comb begin
        gnt_valid = en_i && (req_i != 2'b00);
        case (req_i)
            2'b01:   gnt_idx = PORT_A;
            2'b10:   gnt_idx = PORT_B;
            default: gnt_idx = prio_q;
        endcase
        prio_d = prio_q;
        if (gnt_valid) begin
            prio_d = ~gnt_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= PORT_A;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign gnt_idx_o   = gnt_idx;
    assign gnt_valid_o = gnt_valid;

endmodule

// File: rtl/mem_arbiter.sv
// Host/DMA arbiter in front of a single-port memory controller, one access in flight.
// Define MEM_ARBITER_PERF_EN to build the per-port saturating grant counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 A_REQ,
    input  logic                 B_REQ,
    input  logic                 A_WE,
    input  logic                 B_WE,
    input  logic [ADDR_W-1:0]    A_ADDR,
    input  logic [ADDR_W-1:0]    B_ADDR,
    input  logic [DATA_W-1:0]    A_WDATA,
    input  logic [DATA_W-1:0]    B_WDATA,
    output logic                 A_ACK,
    output logic                 B_ACK,
    output logic                 A_RVALID,
    output logic                 B_RVALID,
    output logic [DATA_W-1:0]    A_RDATA,
    output logic [DATA_W-1:0]    B_RDATA,
    input  logic                 BIST_EN,
    output logic                 BUSY,
    output logic [ADDR_W-1:0]    ADDR,
    output logic                 CE,
    output logic                 CSB,
    output logic                 WEB,
    output logic                 OEB,
    output logic [DATA_W-1:0]    IDATA,
    input  logic [DATA_W-1:0]    ODATA,
    output logic [GNT_CNT_W-1:0] A_GNT_CNT,
    output logic [GNT_CNT_W-1:0] B_GNT_CNT
);

    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic gnt_idx;
    logic gnt_valid;

    mem_arb_rr u_rr (
        .clk_i       (CLK),
        .rst_i       (RST),
        .req_i       ({B_REQ, A_REQ}),
        .en_i        ((state_q == StIdle) && !BIST_EN),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    owner_d = gnt_idx;
                    we_d    = (gnt_idx == PORT_B) ? B_WE    : A_WE;
                    addr_d  = (gnt_idx == PORT_B) ? B_ADDR  : A_ADDR;
                    wdata_d = (gnt_idx == PORT_B) ? B_WDATA : A_WDATA;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                cnt_d   = '0;
                state_d = we_q ? StIdle : StRdWait;
            end
            StRdWait: begin
                // ODATA is valid on the last wait cycle; capture straight into the owner's holder
                if (cnt_q == CNT_LAST) begin
                    if (owner_q == PORT_B) begin
                        b_rdata_d = ODATA;
                    end else begin
                        a_rdata_d = ODATA;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            owner_q   <= PORT_A;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    always_comb begin
        CE       = IDLE_CE;
        CSB      = IDLE_CSB;
        WEB      = IDLE_WEB;
        OEB      = IDLE_OEB;
        A_ACK    = 1'b0;
        B_ACK    = 1'b0;
        A_RVALID = 1'b0;
        B_RVALID = 1'b0;
        case (state_q)
            StCmd: begin
                CE    = 1'b1;
                CSB   = 1'b0;
                WEB   = ~we_q;
                OEB   = we_q;
                A_ACK = (owner_q == PORT_A);
                B_ACK = (owner_q == PORT_B);
            end
            StRdWait: begin
                CE  = 1'b0;
                CSB = 1'b0;
                WEB = 1'b1;
                OEB = 1'b0;
            end
            StResp: begin
                A_RVALID = (owner_q == PORT_A);
                B_RVALID = (owner_q == PORT_B);
            end
            default: begin
            end
        endcase
    end

    assign BUSY    = (state_q != StIdle);
    assign ADDR    = addr_q;
    assign IDATA   = wdata_q;
    assign A_RDATA = a_rdata_q;
    assign B_RDATA = b_rdata_q;

`ifdef MEM_ARBITER_PERF_EN
    logic [GNT_CNT_W-1:0] a_gnt_cnt_q;
    logic [GNT_CNT_W-1:0] b_gnt_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_gnt_cnt_q <= '0;
            b_gnt_cnt_q <= '0;
        end else begin
            if (A_ACK && (a_gnt_cnt_q != '1)) begin
                a_gnt_cnt_q <= a_gnt_cnt_q + 1'b1;
            end
            if (B_ACK && (b_gnt_cnt_q != '1)) begin
                b_gnt_cnt_q <= b_gnt_cnt_q + 1'b1;
            end
        end
    end

    assign A_GNT_CNT = a_gnt_cnt_q;
    assign B_GNT_CNT = b_gnt_cnt_q;
`else
    assign A_GNT_CNT = '0;
    assign B_GNT_CNT = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memctrl and a grant/read scoreboard.
module tb_mem_arbiter;

    localparam int unsigned RD_LAT = 2;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              A_REQ = 1'b0, B_REQ = 1'b0;
    logic              A_WE = 1'b0, B_WE = 1'b0;
    logic [ADDR_W-1:0] A_ADDR = '0, B_ADDR = '0;
    logic [DATA_W-1:0] A_WDATA = '0, B_WDATA = '0;
    logic              BIST_EN = 1'b0;
    logic              A_ACK, B_ACK, A_RVALID, B_RVALID, BUSY;
    logic [DATA_W-1:0] A_RDATA, B_RDATA, IDATA, ODATA;
    logic [ADDR_W-1:0] ADDR;
    logic              CE, CSB, WEB, OEB;
    logic [15:0]       A_GNT_CNT, B_GNT_CNT;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } job_t;

    typedef struct {
        logic       port;
        logic [7:0] data;
    } rd_t;

    job_t a_jobs[$];
    job_t b_jobs[$];
    job_t exp_ack[$];
    rd_t  exp_rd[$];

    bit [7:0] ref_mem[256];
    bit       ref_wr[256];
    bit [7:0] mem[256];
    bit       mem_wr[256];
    bit       s1_v, s2_v;
    bit [7:0] s1_d, s2_d;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .RD_LAT (RD_LAT),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .A_REQ     (A_REQ),
        .B_REQ     (B_REQ),
        .A_WE      (A_WE),
        .B_WE      (B_WE),
        .A_ADDR    (A_ADDR),
        .B_ADDR    (B_ADDR),
        .A_WDATA   (A_WDATA),
        .B_WDATA   (B_WDATA),
        .A_ACK     (A_ACK),
        .B_ACK     (B_ACK),
        .A_RVALID  (A_RVALID),
        .B_RVALID  (B_RVALID),
        .A_RDATA   (A_RDATA),
        .B_RDATA   (B_RDATA),
        .BIST_EN   (BIST_EN),
        .BUSY      (BUSY),
        .ADDR      (ADDR),
        .CE        (CE),
        .CSB       (CSB),
        .WEB       (WEB),
        .OEB       (OEB),
        .IDATA     (IDATA),
        .ODATA     (ODATA),
        .A_GNT_CNT (A_GNT_CNT),
        .B_GNT_CNT (B_GNT_CNT)
    );

    // Memctrl model: read data appears two cycles after the command cycle, zero otherwise.
    always @(posedge CLK) begin
        if (CE && !WEB) begin
            mem[ADDR[7:0]]    <= IDATA;
            mem_wr[ADDR[7:0]] <= 1'b1;
        end
        s1_v <= CE && WEB;
        s1_d <= mem_wr[ADDR[7:0]] ? mem[ADDR[7:0]] : (ADDR[7:0] ^ 8'hA5);
        s2_v <= s1_v;
        s2_d <= s1_d;
    end
    assign ODATA = s2_v ? s2_d : 8'h00;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish before 1ms");
        $fatal(1);
    end

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_wr[a[7:0]] ? ref_mem[a[7:0]] : (a[7:0] ^ 8'hA5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic port, input logic we, input logic [15:0] a,
                       input logic [7:0] d);
        job_t j;
        j.port = port; j.we = we; j.addr = a; j.wdata = d;
        if (port) b_jobs.push_back(j);
        else a_jobs.push_back(j);
    endtask

    task automatic expect_grant(input logic port, input logic we, input logic [15:0] a,
                                input logic [7:0] d);
        job_t j;
        rd_t  r;
        j.port = port; j.we = we; j.addr = a; j.wdata = d;
        exp_ack.push_back(j);
        if (we) begin
            ref_mem[a[7:0]] = d;
            ref_wr[a[7:0]]  = 1'b1;
        end else begin
            r.port = port;
            r.data = ref_rd(a);
            exp_rd.push_back(r);
        end
    endtask

    task automatic issue(input logic port, input logic we, input logic [15:0] a,
                         input logic [7:0] d);
        req(port, we, a, d);
        expect_grant(port, we, a, d);
    endtask

    task automatic drive();
        A_REQ = (a_jobs.size() != 0);
        B_REQ = (b_jobs.size() != 0);
        if (a_jobs.size() != 0) begin
            A_WE = a_jobs[0].we; A_ADDR = a_jobs[0].addr; A_WDATA = a_jobs[0].wdata;
        end
        if (b_jobs.size() != 0) begin
            B_WE = b_jobs[0].we; B_ADDR = b_jobs[0].addr; B_WDATA = b_jobs[0].wdata;
        end
    endtask

    task automatic monitor();
        job_t e;
        rd_t  r;
        if (A_ACK || B_ACK) begin
            chk("ack_overlap", {31'd0, A_ACK && B_ACK}, 0);
            chk("ack_expected", {31'd0, exp_ack.size() != 0}, 1);
            if (exp_ack.size() != 0) begin
                e = exp_ack.pop_front();
                chk("ack_port", {31'd0, B_ACK}, {31'd0, e.port});
                chk("cmd_ce", {31'd0, CE}, 1);
                chk("cmd_csb", {31'd0, CSB}, 0);
                chk("cmd_web", {31'd0, WEB}, {31'd0, ~e.we});
                chk("cmd_oeb", {31'd0, OEB}, {31'd0, e.we});
                chk("cmd_addr", {16'd0, ADDR}, {16'd0, e.addr});
                if (e.we) chk("cmd_idata", {24'd0, IDATA}, {24'd0, e.wdata});
            end
            if (A_ACK && a_jobs.size() != 0) void'(a_jobs.pop_front());
            if (B_ACK && b_jobs.size() != 0) void'(b_jobs.pop_front());
        end
        if (A_RVALID || B_RVALID) begin
            chk("rvalid_overlap", {31'd0, A_RVALID && B_RVALID}, 0);
            chk("rvalid_expected", {31'd0, exp_rd.size() != 0}, 1);
            if (exp_rd.size() != 0) begin
                r = exp_rd.pop_front();
                chk("rvalid_port", {31'd0, B_RVALID}, {31'd0, r.port});
                chk("rdata", {24'd0, r.port ? B_RDATA : A_RDATA}, {24'd0, r.data});
            end
        end
    endtask

    task automatic step();
        @(negedge CLK);
        monitor();
        drive();
    endtask

    task automatic run_idle(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            done = (a_jobs.size() == 0) && (b_jobs.size() == 0) && (exp_ack.size() == 0)
                   && (exp_rd.size() == 0) && !BUSY;
        end
        chk({tag, "_done"}, {31'd0, done}, 1);
    endtask

    initial begin
        // Reset values while RST is held
        step();
        step();
        chk("rst_ack", {30'd0, A_ACK, B_ACK}, 0);
        chk("rst_rvalid", {30'd0, A_RVALID, B_RVALID}, 0);
        chk("rst_rdata", {16'd0, A_RDATA, B_RDATA}, 0);
        chk("rst_addr", {16'd0, ADDR}, 0);
        chk("rst_idata", {24'd0, IDATA}, 0);
        chk("rst_cmd", {28'd0, CE, CSB, WEB, OEB}, 32'b0111);
        chk("rst_busy", {31'd0, BUSY}, 0);
        RST = 1'b0;
        step();

        // Uncontended write: ACK and command one cycle after REQ
        issue(1'b0, 1'b1, 16'h0C05, 8'h5A);
        drive();
        step();
        chk("wr_lat_ack", {31'd0, A_ACK}, 1);
        chk("wr_ce", {31'd0, CE}, 1);
        chk("wr_web", {31'd0, WEB}, 0);
        chk("wr_addr", {16'd0, ADDR}, 32'h0C05);
        chk("wr_idata", {24'd0, IDATA}, 32'h5A);
        run_idle("wr1", 10);
        chk("idle_addr_hold", {16'd0, ADDR}, 32'h0C05);

        issue(1'b0, 1'b1, 16'h0010, 8'h3C);
        drive();
        run_idle("wr2", 10);

        // B read of an unwritten word: memctrl returns A5, RVALID at REQ+4
        issue(1'b1, 1'b0, 16'h0000, 8'h00);
        drive();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rd_early_rvalid", {31'd0, B_RVALID}, 0);
        end
        step();
        chk("rd_lat4_rvalid", {31'd0, B_RVALID}, 1);
        chk("rd_lat4_rdata", {24'd0, B_RDATA}, 32'hA5);
        run_idle("rd1", 10);

        issue(1'b1, 1'b0, 16'h0010, 8'h00);
        drive();
        run_idle("rd2", 10);

        // Both held for four accesses: B was granted last, so A, B, A, B
        issue(1'b0, 1'b0, 16'h0C05, 8'h00);
        issue(1'b1, 1'b1, 16'h0022, 8'h88);
        issue(1'b0, 1'b1, 16'h0021, 8'h77);
        issue(1'b1, 1'b0, 16'h0021, 8'h00);
        drive();
        run_idle("rr4", 40);
        chk("rdata_a_held", {24'd0, A_RDATA}, 32'h5A);
        chk("rdata_b_last", {24'd0, B_RDATA}, 32'h77);

        // BIST raised during an A read wait: A completes, pending B gets nothing
        issue(1'b0, 1'b0, 16'h0022, 8'h00);
        drive();
        step();
        step();
        BIST_EN = 1'b1;
        req(1'b1, 1'b1, 16'h0030, 8'hC3);
        drive();
        for (int i = 0; i < 10; i++) step();
        chk("bist_a_rvalid_seen", exp_rd.size(), 0);
        chk("bist_a_rdata", {24'd0, A_RDATA}, 32'h88);
        chk("bist_busy", {31'd0, BUSY}, 0);
        chk("bist_b_pending", b_jobs.size(), 1);
        BIST_EN = 1'b0;
        expect_grant(1'b1, 1'b1, 16'h0030, 8'hC3);
        run_idle("bist_rel", 10);

        // Reset during a read wait discards it; the following tie goes to A
        issue(1'b0, 1'b0, 16'h0021, 8'h00);
        drive();
        step();
        step();
        RST = 1'b1;
        exp_rd.delete();
        step();
        step();
        chk("rstmid_csb", {31'd0, CSB}, 1);
        chk("rstmid_busy", {31'd0, BUSY}, 0);
        RST = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("rstmid_idle_csb", {31'd0, CSB}, 1);
        issue(1'b0, 1'b1, 16'h0040, 8'h11);
        issue(1'b1, 1'b1, 16'h0041, 8'h22);
        drive();
        step();
        chk("rstmid_tie_a", {30'd0, A_ACK, B_ACK}, 32'b10);
        run_idle("rstmid_tie", 20);

        // Grant counters: 3 A writes + 2 B reads after a fresh reset
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        issue(1'b0, 1'b1, 16'h0050, 8'h01);
        issue(1'b1, 1'b0, 16'h0050, 8'h00);
        issue(1'b0, 1'b1, 16'h0051, 8'h02);
        issue(1'b1, 1'b0, 16'h0051, 8'h00);
        issue(1'b0, 1'b1, 16'h0052, 8'h03);
        drive();
        run_idle("cnt", 60);
`ifdef MEM_ARBITER_PERF_EN
        chk("a_gnt_cnt", {16'd0, A_GNT_CNT}, 3);
        chk("b_gnt_cnt", {16'd0, B_GNT_CNT}, 2);
`else
        chk("a_gnt_cnt", {16'd0, A_GNT_CNT}, 0);
        chk("b_gnt_cnt", {16'd0, B_GNT_CNT}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
